// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select pair, one-hot grant and a registered data sample.
// Optional hold limit on the current owner: define MUX4_RR_ARB_HOLD_LIMIT_EN.
module mux4_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       req_i,
  input  logic [WIDTH-1:0] dataA_i,
  input  logic [WIDTH-1:0] dataB_i,
  input  logic [WIDTH-1:0] dataC_i,
  input  logic [WIDTH-1:0] dataD_i,
  output logic [3:0]       grant_o,
  output logic             select1_o,
  output logic             select2_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             busy_o
);

`ifdef MUX4_RR_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       others;
  logic             hold_rel;
  logic [WIDTH-1:0] owner_data;

  // First set bit of r, searching upward from p and wrapping 3 -> 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] res;
    res = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    others   = req_i & ~(4'b0001 << owner_q);
    hold_rel = HOLD_EN && (cnt_q == HOLD_LAST) && (others != 4'b0000);
    case (state_q)
      IDLE: begin
        if (req_i != 4'b0000) begin
          owner_d = rr_pick(req_i, ptr_q);
          state_d = GRANT;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (req_i[owner_q] && !hold_rel) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // Owner is excluded from the handover search, so it cannot re-win here.
          ptr_d = owner_q + 2'd1;
          cnt_d = '0;
          if (others != 4'b0000) owner_d = rr_pick(others, owner_q + 2'd1);
          else                   state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_data = dataA_i;
    case (owner_q)
      2'd0: owner_data = dataA_i;
      2'd1: owner_data = dataB_i;
      2'd2: owner_data = dataC_i;
      2'd3: owner_data = dataD_i;
      default: owner_data = dataA_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      cnt_q   <= '0;
      grant_o <= 4'b0000;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_o <= (state_d == GRANT) ? (4'b0001 << owner_d) : 4'b0000;
      if (state_q == GRANT && req_i[owner_q]) begin
        data_o  <= owner_data;
        valid_o <= 1'b1;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

  // Selects follow the last owner and are deliberately left in place while idle.
  assign select1_o = owner_q[0];
  assign select2_o = owner_q[1];
  assign busy_o    = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_mux4_rr_arbiter;
  localparam int WIDTH    = 1;
  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;
`ifdef MUX4_RR_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic [3:0]       req_i = 4'b0000;
  logic [WIDTH-1:0] dataA_i = '0, dataB_i = '0, dataC_i = '0, dataD_i = '0;
  logic [3:0]       grant_o;
  logic             select1_o, select2_o, valid_o, busy_o;
  logic [WIDTH-1:0] data_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: who owns the mux, where priority starts, how long the owner has held.
  bit               m_busy;
  int               m_owner, m_ptr, m_cnt;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic [3:0]       m_grant;
  logic [1:0]       m_sel;

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i),
    .dataA_i(dataA_i), .dataB_i(dataB_i), .dataC_i(dataC_i), .dataD_i(dataD_i),
    .grant_o(grant_o), .select1_o(select1_o), .select2_o(select2_o),
    .data_o(data_o), .valid_o(valid_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] data_of(input int i);
    case (i)
      0: return dataA_i;
      1: return dataB_i;
      2: return dataC_i;
      default: return dataD_i;
    endcase
  endfunction

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return p;
  endfunction

  task automatic model_step();
    logic [3:0] oth;
    bit rel;
    if (rst_i) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_data = '0; m_valid = 1'b0;
    end else begin
      if (m_busy && req_i[m_owner]) begin
        m_data  = data_of(m_owner);
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (!m_busy) begin
        if (req_i != 4'b0000) begin
          m_owner = first_from(req_i, m_ptr);
          m_busy  = 1;
          m_cnt   = 0;
        end
      end else begin
        oth = req_i;
        oth[m_owner] = 1'b0;
        rel = !req_i[m_owner] || (HOLD_ON && m_cnt == MAX_HOLD - 1 && oth != 4'b0000);
        if (!rel) begin
          m_cnt = (m_cnt == (1 << CNT_W) - 1) ? m_cnt : m_cnt + 1;
        end else begin
          m_ptr = (m_owner + 1) % 4;
          m_cnt = 0;
          if (oth != 4'b0000) m_owner = first_from(oth, m_ptr);
          else                m_busy  = 0;
        end
      end
    end
    m_grant = 4'b0000;
    if (m_busy) m_grant[m_owner] = 1'b1;
    m_sel = 2'(m_owner);
  endtask

  // Apply inputs, take one rising edge, advance the model, then settle before sampling.
  task automatic tick(input logic [3:0] r, input logic rs);
    req_i = r;
    rst_i = rs;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    tick(4'b1111, 1'b1);
    tick(4'b1111, 1'b1);
    n_cmp++;
    if ({grant_o, select2_o, select1_o, busy_o, valid_o, data_o} !== {4'b0000, 2'b00, 1'b0, 1'b0, {WIDTH{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_idle: got grant=%b sel=%b%b busy=%b valid=%b data=%h, want all zero",
               grant_o, select2_o, select1_o, busy_o, valid_o, data_o);
    end
    dataA_i = '1; dataB_i = '1; dataC_i = '1; dataD_i = '1;
    tick(4'b1111, 1'b0);
    tick(4'b1111, 1'b0);
    tick(4'b1111, 1'b0);
    n_cmp++;
    if (valid_o !== 1'b1 || data_o !== {WIDTH{1'b1}}) begin
      n_fail++;
      $display("FAIL reset_pregrant_valid: got valid=%b data=%h, want valid=1 data=all ones", valid_o, data_o);
    end
    tick(4'b1111, 1'b1);
    n_cmp++;
    if ({grant_o, busy_o, valid_o, data_o} !== {4'b0000, 1'b0, 1'b0, {WIDTH{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_midgrant: got grant=%b busy=%b valid=%b data=%h, want 0000 0 0 0",
               grant_o, busy_o, valid_o, data_o);
    end
    tick(4'b1111, 1'b0);
    n_cmp++;
    if ({grant_o, select2_o, select1_o} !== {4'b0001, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_first_grant: got grant=%b sel=%b%b, want grant=0001 sel=00", grant_o, select2_o, select1_o);
    end
    dataA_i = '0; dataB_i = '0; dataC_i = '0; dataD_i = '0;
  endtask

  task automatic test_single();
    tick(4'b0000, 1'b1);
    dataC_i = '1;
    tick(4'b0100, 1'b0);
    n_cmp++;
    if ({grant_o, select2_o, select1_o, busy_o} !== {4'b0100, 2'b10, 1'b1}) begin
      n_fail++;
      $display("FAIL single_grant: got grant=%b sel2=%b sel1=%b busy=%b, want 0100 1 0 1",
               grant_o, select2_o, select1_o, busy_o);
    end
    tick(4'b0100, 1'b0);
    n_cmp++;
    if ({valid_o, data_o} !== {1'b1, {WIDTH{1'b1}}}) begin
      n_fail++;
      $display("FAIL single_data: got valid=%b data=%h, want valid=1 data=1", valid_o, data_o);
    end
    dataC_i = '0;
  endtask

  task automatic test_rotation();
    logic [3:0] r;
    int exp_o;
    tick(4'b0000, 1'b1);
    tick(4'b1111, 1'b0);
    for (int k = 0; k < 5; k++) begin
      exp_o = k % 4;
      n_cmp++;
      if (grant_o !== 4'(1 << exp_o)) begin
        n_fail++;
        $display("FAIL rotation_order[%0d]: got grant=%b, want %b", k, grant_o, 4'(1 << exp_o));
      end
      tick(4'b1111, 1'b0);
      n_cmp++;
      if (grant_o !== 4'(1 << exp_o) || grant_o !== m_grant) begin
        n_fail++;
        $display("FAIL rotation_hold[%0d]: got grant=%b, want %b", k, grant_o, 4'(1 << exp_o));
      end
      r = 4'b1111;
      r[exp_o] = 1'b0;
      tick(r, 1'b0);
    end
  endtask

  task automatic test_hold();
    int cycles;
    int exp_cycles;
    exp_cycles = HOLD_ON ? MAX_HOLD : 20;
    tick(4'b0000, 1'b1);
    tick(4'b0011, 1'b0);
    cycles = 0;
    while (grant_o == 4'b0001 && cycles < 20) begin
      cycles++;
      n_cmp++;
      if (grant_o !== m_grant) begin
        n_fail++;
        $display("FAIL hold_model: got grant=%b, want %b at cycle %0d", grant_o, m_grant, cycles);
      end
      if (cycles < 20) tick(4'b0011, 1'b0);
    end
    n_cmp++;
    if (cycles != exp_cycles) begin
      n_fail++;
      $display("FAIL hold_length: got %0d cycles for A, want %0d", cycles, exp_cycles);
    end
    if (!HOLD_ON) tick(4'b0010, 1'b0);
    n_cmp++;
    if (grant_o !== 4'b0010) begin
      n_fail++;
      $display("FAIL hold_handover: got grant=%b, want 0010", grant_o);
    end
  endtask

  task automatic test_drop_idle();
    tick(4'b0000, 1'b1);
    tick(4'b0001, 1'b0);
    tick(4'b0001, 1'b0);
    tick(4'b0000, 1'b0);
    n_cmp++;
    if ({grant_o, busy_o, select2_o, select1_o, valid_o} !== {4'b0000, 1'b0, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL drop_idle: got grant=%b busy=%b sel=%b%b valid=%b, want 0000 0 00 0",
               grant_o, busy_o, select2_o, select1_o, valid_o);
    end
    // Selects must stay on the last owner while idle, not return to A.
    tick(4'b0000, 1'b1);
    tick(4'b1000, 1'b0);
    tick(4'b0000, 1'b0);
    n_cmp++;
    if ({grant_o, busy_o, select2_o, select1_o} !== {4'b0000, 1'b0, 2'b11}) begin
      n_fail++;
      $display("FAIL idle_select_keep: got grant=%b busy=%b sel=%b%b, want 0000 0 11",
               grant_o, busy_o, select2_o, select1_o);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       rs;
    tick(4'b0000, 1'b1);
    for (int i = 0; i < 600; i++) begin
      dataA_i = WIDTH'($urandom); dataB_i = WIDTH'($urandom);
      dataC_i = WIDTH'($urandom); dataD_i = WIDTH'($urandom);
      // Mostly sticky requests so holds and hold-limit releases actually occur.
      r  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (req_i | 4'(1 << $urandom_range(0, 3))) & ~4'($urandom_range(0, 15) == 0 ? 4'($urandom) : 4'b0000);
      rs = ($urandom_range(0, 79) == 0);
      tick(r, rs);
      n_cmp++;
      if ({grant_o, select2_o, select1_o, busy_o, valid_o, data_o} !== {m_grant, m_sel, m_busy, m_valid, m_data}) begin
        n_fail++;
        $display("FAIL random[%0d]: got grant=%b sel=%b%b busy=%b valid=%b data=%h, want grant=%b sel=%b busy=%b valid=%b data=%h",
                 i, grant_o, select2_o, select1_o, busy_o, valid_o, data_o, m_grant, m_sel, m_busy, m_valid, m_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_hold();
    test_drop_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
